// File: rtl/inv_fleet_ctrl.sv
// inv_fleet_ctrl: movement sequencer for the invader formation.
// Divides clk down to a programmable step rate and, on each step, issues a
// single one-cycle shift pulse (right, left or down) that every ship sees.
// The formation sweeps horizontally, descends DOWN_STEPS rows at each edge,
// reverses, and freezes for good once any ship reports line_crossed.
module inv_fleet_ctrl #(
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 240,
  parameter int START_X    = 120,
  parameter int STEP_DIV   = 400000,
  parameter int DOWN_STEPS = 15
) (
  input  logic        clk,
  input  logic        on_sw,
  input  logic        en,
  input  logic [2:0]  speed_lvl,
  input  logic        line_crossed,
  output logic        shift_right,
  output logic        shift_left,
  output logic        shift_down,
  output logic [10:0] fleet_x,
  output logic [10:0] rows_down,
  output logic        dir_left,
  output logic        halted
);

  typedef enum logic [2:0] {MOVE_R, DOWN_R, MOVE_L, DOWN_L, HALT} state_t;

  localparam int          DW          = $clog2(DOWN_STEPS + 1);
  localparam logic [23:0] STEP_DIV_W  = 24'(STEP_DIV);
  localparam logic [10:0] X_MIN_W     = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W     = 11'(X_MAX);
  localparam logic [10:0] START_X_W   = 11'(START_X);
  localparam logic [DW-1:0] DOWN_W    = DW'(DOWN_STEPS);

  state_t          state;
  logic [23:0]     step_cnt;
  logic [DW-1:0]   down_cnt;
  logic [23:0]     div;
  logic            tick;
  logic [10:0]     rows_inc;

  // Step divider compare; >= so a mid-count speed-up ticks at once instead of wrapping.
  assign div      = STEP_DIV_W >> speed_lvl;
  assign tick     = (step_cnt >= div - 24'd1);
  // Descent counter saturates rather than wrapping back to zero.
  assign rows_inc = (rows_down == 11'h7FF) ? rows_down : rows_down + 11'd1;

  // Sequencer: divider, state machine and all registered outputs in one block.
  always_ff @(posedge clk or negedge on_sw) begin
    if (!on_sw) begin
      state       <= MOVE_R;
      fleet_x     <= START_X_W;
      rows_down   <= '0;
      step_cnt    <= '0;
      down_cnt    <= '0;
      shift_right <= 1'b0;
      shift_left  <= 1'b0;
      shift_down  <= 1'b0;
      dir_left    <= 1'b0;
      halted      <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch sees the pre-edge values and
      // these defaults are simply overridden below; that keeps each pulse one clock wide.
      shift_right <= 1'b0;
      shift_left  <= 1'b0;
      shift_down  <= 1'b0;
      if (line_crossed) begin
        // Freeze wins over a coincident tick: no pulse, position untouched.
        state  <= HALT;
        halted <= 1'b1;
      end else if (state != HALT && en) begin
        if (!tick) begin
          step_cnt <= step_cnt + 24'd1;
        end else begin
          step_cnt <= '0;
          case (state)
            MOVE_R: begin
              if (fleet_x < X_MAX_W) begin
                shift_right <= 1'b1;
                fleet_x     <= fleet_x + 11'd1;
              end else begin
                shift_down <= 1'b1;
                rows_down  <= rows_inc;
                down_cnt   <= DW'(1);
                state      <= DOWN_R;
                dir_left   <= 1'b1;
              end
            end
            DOWN_R: begin
              if (down_cnt < DOWN_W) begin
                shift_down <= 1'b1;
                rows_down  <= rows_inc;
                down_cnt   <= down_cnt + DW'(1);
              end else begin
                shift_left <= 1'b1;
                fleet_x    <= fleet_x - 11'd1;
                down_cnt   <= '0;
                state      <= MOVE_L;
              end
            end
            MOVE_L: begin
              if (fleet_x > X_MIN_W) begin
                shift_left <= 1'b1;
                fleet_x    <= fleet_x - 11'd1;
              end else begin
                shift_down <= 1'b1;
                rows_down  <= rows_inc;
                down_cnt   <= DW'(1);
                state      <= DOWN_L;
                dir_left   <= 1'b0;
              end
            end
            DOWN_L: begin
              if (down_cnt < DOWN_W) begin
                shift_down <= 1'b1;
                rows_down  <= rows_inc;
                down_cnt   <= down_cnt + DW'(1);
              end else begin
                shift_right <= 1'b1;
                fleet_x     <= fleet_x + 11'd1;
                down_cnt    <= '0;
                state       <= MOVE_R;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/inv_fleet_ctrl.md
# inv_fleet_ctrl

Movement sequencer for the invader formation. It divides `clk` into a programmable step rate and issues one-cycle `shift_right` / `shift_left` / `shift_down` pulses, which fan out to every invader ship instance. The formation sweeps horizontally, descends a fixed number of rows at each edge, reverses direction, and freezes permanently once any ship reports `line_crossed`.

## Interface
Parameters:
- `X_MIN`, 0: leftmost allowed formation x.
- `X_MAX`, 240: rightmost allowed formation x (screen width minus formation width).
- `START_X`, 120: formation x after reset; must lie in [X_MIN, X_MAX].
- `STEP_DIV`, 400000: clocks per step at `speed_lvl` = 0; must be ≥ 128.
- `DOWN_STEPS`, 15: `shift_down` pulses per edge descent; must be ≥ 1.

Ports:
- `clk`, input, 1: system clock; ships sample shift pulses on this same clock.
- `on_sw`, input, 1: asynchronous active-low reset.
- `en`, input, 1: run enable; low pauses all counters in place.
- `speed_lvl`, input, 3: step-rate level; divider = STEP_DIV >> speed_lvl.
- `line_crossed`, input, 1: OR of all ships' `line_crossed`.
- `shift_right`, output, 1: one-cycle move-right pulse.
- `shift_left`, output, 1: one-cycle move-left pulse.
- `shift_down`, output, 1: one-cycle move-down pulse.
- `fleet_x`, output, 11: current formation x offset.
- `rows_down`, output, 11: total `shift_down` pulses issued since reset.
- `dir_left`, output, 1: 1 while the horizontal direction is left.
- `halted`, output, 1: sticky freeze flag.

## Operation
- Reset (`on_sw` = 0, asynchronous) sets: state MOVE_R, `fleet_x` = START_X, `rows_down` = 0, step counter 0, `down_cnt` = 0, all pulses 0, `dir_left` = 0, `halted` = 0.
- Step counter: 24 bits. It increments when `en` = 1 and the state is not HALT. Tick when counter ≥ div−1; on a tick the counter returns to 0. The ≥ compare means a mid-count rise in `speed_lvl` ticks on the next enabled cycle and never wraps.
- States: MOVE_R, DOWN_R, MOVE_L, DOWN_L, HALT. Transitions and actions on a tick:
  - MOVE_R, `fleet_x` < X_MAX: pulse `shift_right`, `fleet_x` +1.
  - MOVE_R, `fleet_x` = X_MAX: pulse `shift_down`, `down_cnt` = 1, go to DOWN_R.
  - DOWN_R: if `down_cnt` < DOWN_STEPS, pulse `shift_down` and `down_cnt` +1. Otherwise, pulse `shift_left`, `fleet_x` −1, `down_cnt` = 0, go to MOVE_L.
  - MOVE_L and DOWN_L mirror MOVE_R and DOWN_R, using X_MIN, `shift_left`, and `shift_right`.
- `dir_left` = 1 in MOVE_L and DOWN_R; 0 in MOVE_R and DOWN_L. It reflects the direction of the next horizontal move.
- `rows_down` increments on every `shift_down` pulse. It saturates at 2047.
- At most one shift pulse is high in any cycle. A pulse is never wider than one clock.
- `line_crossed` = 1 in any cycle, in any state, forces HALT on the next edge:
  - All pulses are 0 from that edge onward.
  - `halted` = 1.
  - `fleet_x` and `rows_down` are frozen.
- HALT is left only by reset.
- `line_crossed` and a tick in the same cycle: HALT wins, no pulse is issued, and `fleet_x` does not change.
- `en` = 0 in a DOWN state holds `down_cnt`. The descent resumes exactly where it stopped.

## Timing
- All outputs are registered. Pulses, `fleet_x`, `rows_down`, and state all update on the same rising edge.
- With `en` = 1 continuously from reset release, the first pulse is high for the cycle after the div-th rising edge. Later pulses follow every div cycles.
- A `speed_lvl` change takes effect at the next tick compare. There is no pipeline delay.
- `line_crossed` to frozen outputs: 1 cycle. `halted` rises on that same edge.
- Reset asserted mid-descent immediately clears pulses and restores START_X. The asynchronous reset path has no clock dependency.

## Test plan
All scenarios use STEP_DIV=4, X_MIN=0, X_MAX=3, START_X=1, DOWN_STEPS=2, and `speed_lvl`=0 unless stated otherwise.
- Sweep: `en`=1 from reset. Expect pulse sequence R, R, D, D, L, L, L, D, D, R, each pulse 4 cycles apart.
  - `fleet_x` goes 2, 3, 3, 3, 2, 1, 0, 0, 0, 1.
  - `rows_down` ends at 4.
  - `dir_left` toggles after the 1st and 3rd descent pulses.
- Speed: set `speed_lvl`=1 mid-count with counter = 3. Expect a tick on the next cycle, then pulses every 2 cycles.
- Pause: drop `en` for 10 cycles between the two descent pulses. Expect no pulses, `down_cnt` held, then exactly one more D followed by L.
- Freeze: assert `line_crossed` for 1 cycle coincident with a tick. Expect no pulse and `halted`=1 the next cycle.
  - `fleet_x` and `rows_down` stay unchanged for 100 more cycles.
- Reset mid-op: assert `on_sw`=0 asynchronously during DOWN_L.
  - Outputs return to reset values before the next clock edge.
  - After release, the sequence restarts with R.
- Pulse check: over a 1000-cycle random `en`/`speed_lvl` run, assert that at most one pulse is high per cycle and `fleet_x` stays within [0, 3].
